// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and constants for the PLL lock sequencer.
//   pll_state_t   - sequencer state encoding (exported on the debug port)
//   CNT_W_DEFAULT - default width of the shared cycle down-counter
//   LOSS_CNT_W    - width of the saturating lock-loss event counter
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_t;

  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned LOSS_CNT_W    = 8;

endpackage

// File: rtl/sync2_ff.sv
// sync2_ff: two-flop synchronizer for a single asynchronous level.
//   clk   - destination clock
//   rst_n - asynchronous active-low clear; both flops clear to 0
//   d     - asynchronous input
//   q     - synchronized output, two clk edges of latency
module sync2_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings up the rPLL that feeds the DDR3 clocks.
// Pulses the PLL reset, waits for LOCK, requires LOCK to stay high for a
// stable window, then releases the downstream reset. Times out and retries a
// bounded number of times, reports failure, and counts lock losses in RUN.
// Runs on the board clock that also drives CLKIN, never on a PLL output.
//
// Build option: PLL_LOSS_RESTART_EN
//   defined   - lock loss in RUN re-issues a full PLL reset pulse
//   undefined - lock loss in RUN waits for lock again without a reset pulse
//
// Ports:
//   clk           in   board clock (same net as PLL CLKIN)
//   resetn        in   asynchronous active-low reset
//   pll_lock      in   PLL LOCK, asynchronous, synchronized internally
//   relock_req    in   single-cycle request; restarts the whole sequence and
//                      wins over every other transition in that cycle
//   pll_reset     out  PLL RESET, active high
//   pll_reset_p   out  PLL RESET_P, active high
//   ready         out  PLL locked and stable
//   sys_resetn    out  active-low reset for the PLL clock domains
//   fail          out  lock retries exhausted
//   lock_loss_cnt out  saturating count of lock losses seen in RUN
//   state_dbg     out  current sequencer state
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_PULSE_CYCLES  = 27,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 2700,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pll_lock,
  input  logic                  relock_req,
  output logic                  pll_reset,
  output logic                  pll_reset_p,
  output logic                  ready,
  output logic                  sys_resetn,
  output logic                  fail,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output pll_state_t            state_dbg
);

  localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]      RESET_LOAD   = CNT_W'(RESET_PULSE_CYCLES);
  localparam logic [CNT_W-1:0]      TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]      STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_ONE      = CNT_W'(1);
  localparam logic [RETRY_W-1:0]    RETRY_MAX    = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0]    RETRY_ONE    = RETRY_W'(1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE     = LOSS_CNT_W'(1);

  pll_state_t            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [RETRY_W-1:0]    retry_cnt, retry_nxt;
  logic [LOSS_CNT_W-1:0] loss_nxt;
  logic                  lock_s;
  logic                  cnt_last;

  sync2_ff u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // The count reaches 0 on this cycle's decrement, so a state loaded with N
  // lasts exactly N cycles (a load of 0 behaves like 1).
  assign cnt_last  = (cnt <= CNT_ONE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? (cnt - CNT_ONE) : '0;
    retry_nxt = retry_cnt;
    loss_nxt  = lock_loss_cnt;
    if (relock_req) begin
      state_nxt = RST_PLL;
      cnt_nxt   = RESET_LOAD;
      retry_nxt = '0;
    end else begin
      unique case (state)
        RST_PLL: begin
          if (cnt_last) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = TIMEOUT_LOAD;
          end
        end
        WAIT_LOCK: begin
          // Lock is checked first so it wins against the terminal count.
          if (lock_s) begin
            state_nxt = STABLE;
            cnt_nxt   = STABLE_LOAD;
          end else if (cnt_last) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_nxt = retry_cnt + RETRY_ONE;
              state_nxt = RST_PLL;
              cnt_nxt   = RESET_LOAD;
            end else begin
              state_nxt = FAIL;
            end
          end
        end
        STABLE: begin
          // A glitch restarts the wait without consuming a retry.
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = TIMEOUT_LOAD;
          end else if (cnt_last) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          retry_nxt = '0;
          if (!lock_s) begin
            if (lock_loss_cnt != '1) begin
              loss_nxt = lock_loss_cnt + LOSS_ONE;
            end
`ifdef PLL_LOSS_RESTART_EN
            state_nxt = RST_PLL;
            cnt_nxt   = RESET_LOAD;
`else
            state_nxt = WAIT_LOCK;
            cnt_nxt   = TIMEOUT_LOAD;
`endif
          end
        end
        FAIL: begin
          state_nxt = FAIL;
        end
        default: begin
          state_nxt = RST_PLL;
          cnt_nxt   = RESET_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= RST_PLL;
      cnt           <= RESET_LOAD;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_reset     <= 1'b1;
      pll_reset_p   <= 1'b1;
      ready         <= 1'b0;
      sys_resetn    <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_cnt     <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
      // Outputs are registered from the next state so the PLL reset pins
      // never see decode glitches.
      pll_reset     <= (state_nxt == RST_PLL);
      pll_reset_p   <= (state_nxt == RST_PLL);
      fail          <= (state_nxt == FAIL);
      // ready and sys_resetn share one term: they rise the cycle after RUN
      // entry and fall on the same edge that leaves RUN.
      ready         <= (state == RUN) && (state_nxt == RUN);
      sys_resetn    <= (state == RUN) && (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed bench for pll_lock_sequencer.
// Timing windows are shortened (timeout 400, stable 60) to keep runs short;
// the reset pulse keeps its 27-cycle default.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int RP = 27;
  localparam int TO = 400;
  localparam int LS = 60;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_reset, pll_reset_p, ready, sys_resetn, fail;
  logic [7:0] lock_loss_cnt;
  pll_state_t state_dbg;

  int checks = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .RESET_PULSE_CYCLES  (RP),
    .LOCK_TIMEOUT_CYCLES (TO),
    .LOCK_STABLE_CYCLES  (LS),
    .MAX_RETRIES         (MR),
    .CNT_W               (16)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pll_lock      (pll_lock),
    .relock_req    (relock_req),
    .pll_reset     (pll_reset),
    .pll_reset_p   (pll_reset_p),
    .ready         (ready),
    .sys_resetn    (sys_resetn),
    .fail          (fail),
    .lock_loss_cnt (lock_loss_cnt),
    .state_dbg     (state_dbg)
  );

  task automatic test_reset();
    pll_lock = 1'b0;
    relock_req = 1'b0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pll_reset !== 1'b1) begin fails++; $display("FAIL rst_pll_reset got %b exp 1", pll_reset); end
    checks++; if (pll_reset_p !== 1'b1) begin fails++; $display("FAIL rst_pll_reset_p got %b exp 1", pll_reset_p); end
    checks++; if (ready !== 1'b0 || sys_resetn !== 1'b0) begin fails++; $display("FAIL rst_ready got %b/%b exp 0/0", ready, sys_resetn); end
    checks++; if (fail !== 1'b0) begin fails++; $display("FAIL rst_fail got %b exp 0", fail); end
    checks++; if (lock_loss_cnt !== 8'd0) begin fails++; $display("FAIL rst_loss_cnt got %0d exp 0", lock_loss_cnt); end
    checks++; if (state_dbg !== RST_PLL) begin fails++; $display("FAIL rst_state got %0d exp %0d", state_dbg, RST_PLL); end
  endtask

  // Release reset, lock arrives before edge 50.
  task automatic test_lock_up();
    int fall_n = -1, fallp_n = -1, rdy_n = -1;
    bit sys_mismatch = 0;
    @(negedge clk); resetn = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      if (n == 50) pll_lock = 1'b1;
      @(posedge clk); #1;
      if (!pll_reset && fall_n < 0) fall_n = n;
      if (!pll_reset_p && fallp_n < 0) fallp_n = n;
      if (ready && rdy_n < 0) rdy_n = n;
      if (sys_resetn !== ready) sys_mismatch = 1;
    end
    checks++; if (fall_n != RP) begin fails++; $display("FAIL up_pulse_width got %0d exp %0d", fall_n, RP); end
    checks++; if (fallp_n != RP) begin fails++; $display("FAIL up_pulse_p_width got %0d exp %0d", fallp_n, RP); end
    // 2 sync + 1 decision + stable window + 1 registered output
    checks++; if (rdy_n != 49 + 2 + 1 + LS + 1) begin fails++; $display("FAIL up_ready_latency got %0d exp %0d", rdy_n, 49 + 2 + 1 + LS + 1); end
    checks++; if (sys_mismatch) begin fails++; $display("FAIL up_sys_resetn_tracks got mismatch exp equal"); end
    checks++; if (state_dbg !== RUN) begin fails++; $display("FAIL up_state got %0d exp %0d", state_dbg, RUN); end
  endtask

  // Lock glitch in STABLE at remaining count 30.
  task automatic test_stable_glitch();
    int stable_n = -1, wait_n = -1, rdy_n = -1, rst_hi = 0;
    @(negedge clk); resetn = 1'b0; pll_lock = 1'b1;
    @(negedge clk); resetn = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      if (n == 59) pll_lock = 1'b0;
      if (n == 64) pll_lock = 1'b1;
      @(posedge clk); #1;
      if (state_dbg == STABLE && stable_n < 0) stable_n = n;
      if (stable_n > 0 && state_dbg == WAIT_LOCK && wait_n < 0) wait_n = n;
      if (ready && rdy_n < 0) rdy_n = n;
      if (n >= RP && pll_reset) rst_hi++;
    end
    checks++; if (stable_n != RP + 1) begin fails++; $display("FAIL gl_stable_entry got %0d exp %0d", stable_n, RP + 1); end
    checks++; if (wait_n != 61) begin fails++; $display("FAIL gl_back_to_wait got %0d exp 61", wait_n); end
    checks++; if (rdy_n != 63 + LS + 4) begin fails++; $display("FAIL gl_full_restart got %0d exp %0d", rdy_n, 63 + LS + 4); end
    checks++; if (rst_hi != 0) begin fails++; $display("FAIL gl_no_pulse got %0d exp 0", rst_hi); end
    checks++; if (lock_loss_cnt !== 8'd0) begin fails++; $display("FAIL gl_loss_cnt got %0d exp 0", lock_loss_cnt); end
  endtask

  // Lock drops for 10 cycles while in RUN.
  task automatic test_run_loss();
    int drop_n = -1, back_n = -1, rst_hi = 0;
    logic [7:0] cnt_at_drop = 8'hxx;
    for (int n = 1; n <= 200; n++) begin
      if (n == 1) pll_lock = 1'b0;
      if (n == 11) pll_lock = 1'b1;
      @(posedge clk); #1;
      if (!ready && drop_n < 0) begin drop_n = n; cnt_at_drop = lock_loss_cnt; end
      if (drop_n > 0 && ready && back_n < 0) back_n = n;
      if (pll_reset) rst_hi++;
    end
    checks++; if (drop_n != 3) begin fails++; $display("FAIL loss_ready_drop got %0d exp 3", drop_n); end
    checks++; if (cnt_at_drop !== 8'd1) begin fails++; $display("FAIL loss_cnt got %0d exp 1", cnt_at_drop); end
`ifdef PLL_LOSS_RESTART_EN
    checks++; if (rst_hi != RP) begin fails++; $display("FAIL loss_pulse got %0d exp %0d", rst_hi, RP); end
    checks++; if (back_n != 3 + RP + 1 + LS + 1) begin fails++; $display("FAIL loss_ready_back got %0d exp %0d", back_n, 3 + RP + 1 + LS + 1); end
`else
    checks++; if (rst_hi != 0) begin fails++; $display("FAIL loss_pulse got %0d exp 0", rst_hi); end
    checks++; if (back_n != 10 + LS + 4) begin fails++; $display("FAIL loss_ready_back got %0d exp %0d", back_n, 10 + LS + 4); end
`endif
  endtask

  // No lock at all: initial pulse plus MR retries, then FAIL.
  task automatic test_retry_fail();
    int rise_n[8];
    int fall_n[8];
    int pulses = 1, fail_n = -1;
    bit prev = 1'b1, p_mismatch = 0, width_bad = 0, gap_bad = 0;
    for (int i = 0; i < 8; i++) begin rise_n[i] = -1; fall_n[i] = -1; end
    rise_n[0] = 0;
    @(negedge clk); resetn = 1'b0; pll_lock = 1'b0;
    @(negedge clk); resetn = 1'b1;
    for (int n = 1; n <= 4 * (RP + TO) + 50; n++) begin
      @(posedge clk); #1;
      if (pll_reset && !prev && pulses < 8) begin rise_n[pulses] = n; pulses++; end
      if (!pll_reset && prev && pulses <= 8) fall_n[pulses-1] = n;
      if (fail && fail_n < 0) fail_n = n;
      if (pll_reset_p !== pll_reset) p_mismatch = 1;
      prev = pll_reset;
    end
    for (int i = 0; i < 4; i++) begin
      if (fall_n[i] - rise_n[i] != RP) width_bad = 1;
      if (i > 0 && rise_n[i] - fall_n[i-1] != TO) gap_bad = 1;
    end
    checks++; if (pulses != MR + 1) begin fails++; $display("FAIL rf_pulse_count got %0d exp %0d", pulses, MR + 1); end
    checks++; if (width_bad) begin fails++; $display("FAIL rf_pulse_width got %0d exp %0d", fall_n[1] - rise_n[1], RP); end
    checks++; if (gap_bad) begin fails++; $display("FAIL rf_timeout_gap got %0d exp %0d", rise_n[1] - fall_n[0], TO); end
    checks++; if (fail_n != 4 * RP + 4 * TO) begin fails++; $display("FAIL rf_fail_time got %0d exp %0d", fail_n, 4 * RP + 4 * TO); end
    checks++; if (fail !== 1'b1 || pll_reset !== 1'b0 || ready !== 1'b0) begin fails++; $display("FAIL rf_fail_hold got fail=%b rst=%b rdy=%b exp 1/0/0", fail, pll_reset, ready); end
    checks++; if (p_mismatch) begin fails++; $display("FAIL rf_reset_p_tracks got mismatch exp equal"); end
  endtask

  // relock_req from FAIL with lock present.
  task automatic test_relock();
    int fall_n = -1, rdy_n = -1;
    bit fail_seen = 0;
    logic f1 = 1'bx, r1 = 1'bx;
    for (int n = 1; n <= 150; n++) begin
      if (n == 1) begin pll_lock = 1'b1; relock_req = 1'b1; end
      if (n == 2) relock_req = 1'b0;
      @(posedge clk); #1;
      if (n == 1) begin f1 = fail; r1 = pll_reset; end
      if (fail) fail_seen = 1;
      if (n > 1 && !pll_reset && fall_n < 0) fall_n = n;
      if (ready && rdy_n < 0) rdy_n = n;
    end
    checks++; if (f1 !== 1'b0) begin fails++; $display("FAIL rl_fail_clear got %b exp 0", f1); end
    checks++; if (r1 !== 1'b1) begin fails++; $display("FAIL rl_pulse_start got %b exp 1", r1); end
    checks++; if (fall_n != 1 + RP) begin fails++; $display("FAIL rl_pulse_end got %0d exp %0d", fall_n, 1 + RP); end
    checks++; if (rdy_n != 1 + RP + 1 + LS + 1) begin fails++; $display("FAIL rl_ready got %0d exp %0d", rdy_n, 1 + RP + 1 + LS + 1); end
    checks++; if (fail_seen) begin fails++; $display("FAIL rl_fail_stays_low got 1 exp 0"); end
  endtask

  // 256 lock losses; the counter must stop at 255.
  task automatic test_loss_saturation();
    bit ok;
    for (int i = 1; i <= 256; i++) exp_q.push_back((i > 255) ? 8'd255 : 8'(i));
    for (int i = 1; i <= 256; i++) begin
      logic [7:0] exp_v;
      pll_lock = 1'b0;
      ok = 0;
      for (int n = 0; n < 20; n++) begin
        @(posedge clk); #1;
        if (!ready) begin ok = 1; break; end
      end
      pll_lock = 1'b1;
      if (ok) begin
        ok = 0;
        for (int n = 0; n < 200; n++) begin
          @(posedge clk); #1;
          if (ready) begin ok = 1; break; end
        end
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (!ok) begin fails++; $display("FAIL sat_timeout got no ready cycle at loss %0d exp ready", i); return; end
      if (lock_loss_cnt !== exp_v) begin fails++; $display("FAIL sat_loss_cnt got %0d exp %0d at loss %0d", lock_loss_cnt, exp_v, i); end
    end
  endtask

  // resetn asserted between edges while in STABLE.
  task automatic test_async_reset();
    bit ok = 0;
    pll_lock = 1'b0;
    repeat (4) @(posedge clk);
    #1 pll_lock = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (state_dbg == STABLE) begin ok = 1; break; end
    end
    checks++; if (!ok) begin fails++; $display("FAIL ar_reach_stable got %0d exp %0d", state_dbg, STABLE); end
    repeat (10) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    checks++; if (state_dbg !== RST_PLL) begin fails++; $display("FAIL ar_state got %0d exp %0d", state_dbg, RST_PLL); end
    checks++; if (pll_reset !== 1'b1 || pll_reset_p !== 1'b1) begin fails++; $display("FAIL ar_pll_reset got %b/%b exp 1/1", pll_reset, pll_reset_p); end
    checks++; if (ready !== 1'b0 || sys_resetn !== 1'b0 || fail !== 1'b0) begin fails++; $display("FAIL ar_outputs got %b/%b/%b exp 0/0/0", ready, sys_resetn, fail); end
    checks++; if (lock_loss_cnt !== 8'd0) begin fails++; $display("FAIL ar_loss_cnt got %0d exp 0", lock_loss_cnt); end
    @(negedge clk); resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_stable_glitch();
    test_run_loss();
    test_retry_fail();
    test_relock();
    test_loss_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
